// File: rtl/alu_issue_ctrl_if.sv
// Issue/writeback controller bus: instruction handshake, ALU link, host port.
// master = core/ALU side, slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [AW-1:0]     instr_dst;
    logic [AW-1:0]     instr_srca;
    logic [AW-1:0]     instr_srcb;

    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_z;

    logic              done;
    logic              err;
    logic              zero_flag;

    logic              host_we;
    logic [AW-1:0]     host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [AW-1:0]     host_raddr;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output instr_valid, instr_op, instr_dst, instr_srca, instr_srcb,
        output alu_result, alu_z,
        output host_we, host_addr, host_wdata, host_raddr,
        input  instr_ready, alu_in1, alu_in2, alu_op,
        input  done, err, zero_flag, host_rdata
    );

    modport slave (
        input  instr_valid, instr_op, instr_dst, instr_srca, instr_srcb,
        input  alu_result, alu_z,
        input  host_we, host_addr, host_wdata, host_raddr,
        output instr_ready, alu_in1, alu_in2, alu_op,
        output done, err, zero_flag, host_rdata
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around a registered 16-bit ALU.
// One instruction per four cycles: accept, ALU result, ALU z flag, writeback.
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = 3
) (
    input  logic           clock,
    input  logic           reset_n,
    alu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        RES  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              ready;
    logic              done;
    logic              err;
    logic              accept;
    logic              op_legal;
    logic              legal_q;
    logic [AW-1:0]     dst_q;
    logic              wb_we;
    logic              host_blocked;

    logic [DATA_W-1:0] in1_q;
    logic [DATA_W-1:0] in2_q;
    logic [2:0]        op_q;
    logic              zero_q;

    logic [DATA_W-1:0] regs [NREGS];

    assign accept = bus.instr_valid && ready;
    assign wb_we  = (state == WB) && legal_q;

    always_comb begin
        op_legal = 1'b0;
        unique case (1'b1)
            (bus.instr_op == 3'd1): op_legal = 1'b1;
            (bus.instr_op == 3'd2): op_legal = 1'b1;
            (bus.instr_op == 3'd3): op_legal = 1'b1;
            default:                op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = OP;
            OP:   state_nxt = RES;
            RES:  state_nxt = WB;
            WB:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        err   = 1'b0;
        unique case (state)
            IDLE: ready = 1'b1;
            WB: begin
                done = 1'b1;
                err  = ~legal_q;
            end
            default: ;
        endcase
    end

    // Operands are snapshotted at accept; alu_op drops after one cycle so the ALU holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= '0;
            dst_q   <= '0;
            legal_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            if (accept) begin
                in2_q   <= regs[bus.instr_srca];
                in1_q   <= regs[bus.instr_srcb];
                op_q    <= op_legal ? bus.instr_op : 3'd0;
                dst_q   <= bus.instr_dst;
                legal_q <= op_legal;
            end else if (state == OP) begin
                op_q <= 3'd0;
            end
            if (wb_we) begin
                zero_q <= ~bus.alu_z;
            end
        end
    end

    // Writeback takes priority over a host write to the same register.
    assign host_blocked = wb_we && (bus.host_addr == dst_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (bus.host_we && !host_blocked) begin
                regs[bus.host_addr] <= bus.host_wdata;
            end
            if (wb_we) begin
                regs[dst_q] <= bus.alu_result;
            end
        end
    end

    assign bus.instr_ready = ready;
    assign bus.done        = done;
    assign bus.err         = err;
    assign bus.alu_in1     = in1_q;
    assign bus.alu_in2     = in2_q;
    assign bus.alu_op      = op_q;
    assign bus.zero_flag   = zero_q;
    assign bus.host_rdata  = regs[bus.host_raddr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU model, register-file reference, directed and random tests.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    alu_issue_ctrl_if #(.DATA_W(16), .AW(3)) bus ();

    alu_issue_ctrl #(.DATA_W(16), .NREGS(8), .AW(3)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] ref_regs [8];
    logic        ref_zero;

    // Registered ALU: result on alu_op != 0, z one cycle later from held result.
    logic [15:0] alu_out;
    logic        alu_zq;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_out <= '0;
            alu_zq  <= 1'b0;
        end else begin
            alu_zq <= (alu_out != 16'd0);
            case (bus.alu_op)
                3'd1: alu_out <= bus.alu_in1 * bus.alu_in2;
                3'd2: alu_out <= bus.alu_in1 + bus.alu_in2;
                3'd3: alu_out <= bus.alu_in2 - bus.alu_in1;
                default: ;
            endcase
        end
    end
    assign bus.alu_result = alu_out;
    assign bus.alu_z      = alu_zq;

    task automatic host_write(input int addr, input logic [15:0] data);
        @(negedge clock);
        bus.host_we    = 1'b1;
        bus.host_addr  = addr[2:0];
        bus.host_wdata = data;
        @(posedge clock);
        #1 bus.host_we = 1'b0;
        ref_regs[addr] = data;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.host_raddr = i[2:0];
            #1;
            checks++;
            if (bus.host_rdata !== ref_regs[i]) begin
                failures++;
                $display("FAIL %s reg[%0d] got=%h exp=%h", tag, i, bus.host_rdata, ref_regs[i]);
            end
        end
    endtask

    // hw_phase: 0 none, k = host write driven in cycle k after accept (1=OP, 3=WB)
    task automatic run_instr(input string tag, input logic [2:0] op, input int dst,
                             input int a, input int b, input int hw_phase,
                             input int hw_addr, input logic [15:0] hw_data);
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] r;
        logic [2:0]  exp_op;
        bit          legal;
        va = ref_regs[a];
        vb = ref_regs[b];
        legal = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
        case (op)
            3'd1: r = va * vb;
            3'd2: r = va + vb;
            3'd3: r = va - vb;
            default: r = 16'd0;
        endcase
        exp_op = legal ? op : 3'd0;

        @(negedge clock);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_dst   = dst[2:0];
        bus.instr_srca  = a[2:0];
        bus.instr_srcb  = b[2:0];
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_idle got=%b exp=1", tag, bus.instr_ready);
        end
        @(posedge clock);
        #1 bus.instr_valid = 1'b0;

        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            bus.host_we = 1'b0;
            if (hw_phase == k) begin
                bus.host_we    = 1'b1;
                bus.host_addr  = hw_addr[2:0];
                bus.host_wdata = hw_data;
            end
            checks++;
            if (bus.alu_op !== ((k == 1) ? exp_op : 3'd0)) begin
                failures++;
                $display("FAIL %s alu_op c%0d got=%0d exp=%0d", tag, k, bus.alu_op,
                         (k == 1) ? exp_op : 3'd0);
            end
            checks++;
            if (bus.done !== (k == 3)) begin
                failures++;
                $display("FAIL %s done c%0d got=%b exp=%b", tag, k, bus.done, k == 3);
            end
            checks++;
            if (bus.err !== (k == 3 && !legal)) begin
                failures++;
                $display("FAIL %s err c%0d got=%b exp=%b", tag, k, bus.err, k == 3 && !legal);
            end
            if (k == 1 && legal) begin
                checks++;
                if (bus.alu_in2 !== va || bus.alu_in1 !== vb) begin
                    failures++;
                    $display("FAIL %s operands got=%h/%h exp=%h/%h", tag,
                             bus.alu_in2, bus.alu_in1, va, vb);
                end
            end
        end
        @(posedge clock);
        #1 bus.host_we = 1'b0;

        if (hw_phase != 0) ref_regs[hw_addr] = hw_data;
        if (legal) begin
            ref_regs[dst] = r;
            ref_zero = (r == 16'd0);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s post_wb done=%b ready=%b exp done=0 ready=1", tag,
                     bus.done, bus.instr_ready);
        end
        checks++;
        if (bus.zero_flag !== ref_zero) begin
            failures++;
            $display("FAIL %s zero_flag got=%b exp=%b", tag, bus.zero_flag, ref_zero);
        end
        check_regs(tag);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.zero_flag !== 1'b0 ||
            bus.alu_op !== 3'd0 || bus.alu_in1 !== 16'd0 || bus.alu_in2 !== 16'd0) begin
            failures++;
            $display("FAIL reset outs done=%b err=%b z=%b op=%0d in1=%h in2=%h exp all 0",
                     bus.done, bus.err, bus.zero_flag, bus.alu_op, bus.alu_in1, bus.alu_in2);
        end
        @(negedge clock);
        reset_n = 1'b1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset ready got=%b exp=1", bus.instr_ready);
        end
        check_regs("reset");
    endtask

    task automatic test_arith();
        host_write(1, 16'd3);
        host_write(2, 16'd6);
        run_instr("mul", 3'd1, 0, 1, 2, 0, 0, 16'd0);
        host_write(1, 16'd4);
        run_instr("sub", 3'd3, 3, 2, 1, 0, 0, 16'd0);
        run_instr("sub_zero", 3'd3, 4, 1, 1, 0, 0, 16'd0);
        host_write(1, 16'h0102);
        host_write(2, 16'h0100);
        run_instr("mul_trunc", 3'd1, 0, 1, 2, 0, 0, 16'd0);
        host_write(1, 16'hFFFF);
        host_write(2, 16'h0001);
        run_instr("add_wrap", 3'd2, 0, 1, 2, 0, 0, 16'd0);
    endtask

    task automatic test_illegal();
        host_write(5, 16'h1234);
        run_instr("ill5", 3'd5, 5, 1, 2, 0, 0, 16'd0);
        run_instr("ill0", 3'd0, 5, 1, 2, 0, 0, 16'd0);
    endtask

    task automatic test_conflict();
        host_write(1, 16'd10);
        host_write(2, 16'd20);
        run_instr("wb_wins", 3'd2, 3, 1, 2, 3, 3, 16'hBEEF);
        run_instr("both_land", 3'd2, 4, 1, 2, 3, 6, 16'hCAFE);
        run_instr("snapshot", 3'd2, 5, 1, 2, 1, 1, 16'h7777);
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int dn[$];
        host_write(5, 16'd10);
        host_write(6, 16'd7);
        @(negedge clock);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'd2;
        bus.instr_dst   = 3'd5;
        bus.instr_srca  = 3'd5;
        bus.instr_srcb  = 3'd6;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clock);
            if (bus.instr_ready === 1'b1) acc.push_back(c);
            if (bus.done === 1'b1) dn.push_back(c);
            if (c == 11) bus.instr_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        checks++;
        if (acc.size() != 3 || acc[0] != 0 || acc[1] != 4 || acc[2] != 8) begin
            failures++;
            $display("FAIL b2b accept_cycles got n=%0d %p exp 0,4,8", acc.size(), acc);
        end
        checks++;
        if (dn.size() != 3 || dn[0] != 3 || dn[1] != 7 || dn[2] != 11) begin
            failures++;
            $display("FAIL b2b done_cycles got n=%0d %p exp 3,7,11", dn.size(), dn);
        end
        for (int i = 0; i < 3; i++) ref_regs[5] = ref_regs[5] + ref_regs[6];
        ref_zero = (ref_regs[5] == 16'd0);
        checks++;
        if (bus.zero_flag !== ref_zero) begin
            failures++;
            $display("FAIL b2b zero_flag got=%b exp=%b", bus.zero_flag, ref_zero);
        end
        check_regs("b2b");
    endtask

    task automatic test_reset_mid();
        host_write(1, 16'd9);
        host_write(2, 16'd5);
        run_instr("pre_zero", 3'd3, 4, 1, 1, 0, 0, 16'd0);
        @(negedge clock);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 3'd1;
        bus.instr_dst   = 3'd0;
        bus.instr_srca  = 3'd1;
        bus.instr_srcb  = 3'd2;
        @(posedge clock);
        #1 bus.instr_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.zero_flag !== 1'b0 ||
            bus.alu_op !== 3'd0 || bus.alu_in1 !== 16'd0 || bus.alu_in2 !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid outs done=%b err=%b z=%b op=%0d in1=%h in2=%h exp all 0",
                     bus.done, bus.err, bus.zero_flag, bus.alu_op, bus.alu_in1, bus.alu_in2);
        end
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
        ref_zero = 1'b0;
        check_regs("rst_mid");
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if (bus.done !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid stray_done c%0d got=%b exp=0", c, bus.done);
            end
        end
        host_write(1, 16'd3);
        host_write(2, 16'd6);
        run_instr("after_rst", 3'd1, 0, 1, 2, 0, 0, 16'd0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            if ($urandom_range(0, 2) == 0)
                host_write($urandom_range(0, 7), 16'($urandom_range(0, 65535)));
            op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'($urandom_range(1, 3));
            run_instr("rand", op, $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
                      16'($urandom_range(0, 65535)));
        end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_op    = 3'd0;
        bus.instr_dst   = 3'd0;
        bus.instr_srca  = 3'd0;
        bus.instr_srcb  = 3'd0;
        bus.host_we     = 1'b0;
        bus.host_addr   = 3'd0;
        bus.host_wdata  = 16'd0;
        bus.host_raddr  = 3'd0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
        ref_zero = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        test_arith();
        test_illegal();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
